// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the 7-segment display blocks.
//   state_e  - scan controller states {IDLE, SHOW, GAP}
//   SEG_BLANK - all segments off (active-low), decimal point off
//   SEG_LUT  - hex digit -> active-low {dp,g,f,e,d,c,b,a}; A-F use the
//              lowercase b and d shapes so they stay distinct from 8 and 0
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Entry 15 is listed first so that SEG_LUT[n] is the pattern for nibble n.
    localparam logic [15:0][7:0] SEG_LUT = {
        8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E d C
        8'h83, 8'h88, 8'h90, 8'h80,   // b A 9 8
        8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
        8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
    };

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational hex nibble to active-low segment decoder.
//   nibble - 4-bit value 0..F
//   seg_n  - active-low {dp,g,f,e,d,c,b,a}, dp always 1
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg_n
);

    assign seg_n = SEG_LUT[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a common-anode
// 7-segment display. Each enabled digit is lit for DWELL_CYC cycles,
// followed by BLANK_CYC dark cycles; digit data is snapshotted once per frame.
//   clk, rst    - clock, synchronous active-high reset
//   scan_en     - 1 = scanning enabled
//   digit_mask  - per-position participation in the scan
//   digit_data  - nibble for digit i at [4i+3:4i]
//   dig_en_n    - active-low digit enables (one low or all high)
//   num         - nibble of the lit digit, 0 when dark
//   seg_n       - active-low segment pattern {dp,g,f,e,d,c,b,a}
//   frame_tick  - one-cycle pulse coincident with the first digit of a frame
// Optional: define SEG_LZB_EN for leading-zero blanking.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS    = 8,
    parameter int DWELL_CYC = 100000,
    parameter int BLANK_CYC = 1000
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scan_en,
    input  logic [DIGITS-1:0]     digit_mask,
    input  logic [4*DIGITS-1:0]   digit_data,
    output logic [DIGITS-1:0]     dig_en_n,
    output logic [3:0]            num,
    output logic [7:0]            seg_n,
    output logic                  frame_tick
);

    localparam int IW   = $clog2(DIGITS);
    localparam int TMAX = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
    // Floor of one bit keeps the counter legal when both periods are 1.
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_CYC - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

    state_e                state;
    logic [IW-1:0]         idx;
    logic [TW-1:0]         timer;
    logic [4*DIGITS-1:0]   snapshot;

    logic [IW-1:0]         low_idx, up_idx, tgt_idx;
    logic                  up_found, fresh, last, adv;
    logic [3:0]            tgt_num;
    logic [DIGITS-1:0]     tgt_en_n;
    logic                  tgt_blank;
    logic [7:0]            tgt_seg;

`ifdef SEG_LZB_EN
    logic [DIGITS-1:0]     blank_q, lz_fresh;

    // Positions enabled at snapshot that sit above the highest enabled
    // nonzero nibble are blanked; the lowest enabled position never is.
    function automatic logic [DIGITS-1:0] lz_blank(input logic [4*DIGITS-1:0] d,
                                                   input logic [DIGITS-1:0]   m);
        logic              seen, low_done;
        logic [DIGITS-1:0] b;
        b    = '0;
        seen = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (m[i]) begin
                if (d[4*i +: 4] != 4'h0) seen = 1'b1;
                b[i] = !seen;
            end
        end
        low_done = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (m[i] && !low_done) begin
                b[i]     = 1'b0;
                low_done = 1'b1;
            end
        end
        return b;
    endfunction

    assign lz_fresh = lz_blank(digit_data, digit_mask);
`endif

    // Next-digit selection and the output values for a digit about to be lit.
    // A fresh frame (start from IDLE, or wrap) reads the live data instead of
    // the snapshot so the lit nibble matches the snapshot being taken.
    always_comb begin
        low_idx  = '0;
        up_idx   = '0;
        up_found = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (digit_mask[i]) low_idx = IW'(i);
            if (digit_mask[i] && (IW'(i) > idx)) begin
                up_idx   = IW'(i);
                up_found = 1'b1;
            end
        end
        fresh   = (state == IDLE) || !up_found;
        tgt_idx = fresh ? low_idx : up_idx;

        tgt_num  = 4'h0;
        tgt_en_n = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (IW'(i) == tgt_idx) begin
                tgt_num     = fresh ? digit_data[4*i +: 4] : snapshot[4*i +: 4];
                tgt_en_n[i] = 1'b0;
            end
        end
`ifdef SEG_LZB_EN
        tgt_blank = fresh ? lz_fresh[tgt_idx] : blank_q[tgt_idx];
`else
        tgt_blank = 1'b0;
`endif
        last = (state == SHOW) ? (timer == DWELL_LAST) : (timer == BLANK_LAST);
        adv  = (state == IDLE) ||
               ((state == GAP) && last) ||
               ((state == SHOW) && last && (BLANK_CYC == 0));
    end

    seg_hex_decode u_dec (
        .nibble (tgt_num),
        .seg_n  (tgt_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            timer      <= '0;
            snapshot   <= '0;
            dig_en_n   <= '1;
            num        <= 4'h0;
            seg_n      <= SEG_BLANK;
            frame_tick <= 1'b0;
`ifdef SEG_LZB_EN
            blank_q    <= '0;
`endif
        end else begin
            frame_tick <= 1'b0;
            if (!scan_en) begin
                state    <= IDLE;
                timer    <= '0;
                dig_en_n <= '1;
                num      <= 4'h0;
                seg_n    <= SEG_BLANK;
            end else if (adv) begin
                // Mask is consulted only here, so a cleared bit never cuts a dwell short.
                timer <= '0;
                if (digit_mask == '0) begin
                    state    <= IDLE;
                    dig_en_n <= '1;
                    num      <= 4'h0;
                    seg_n    <= SEG_BLANK;
                end else begin
                    state    <= SHOW;
                    idx      <= tgt_idx;
                    dig_en_n <= tgt_en_n;
                    num      <= tgt_blank ? 4'h0 : tgt_num;
                    seg_n    <= tgt_blank ? SEG_BLANK : tgt_seg;
                    if (fresh) begin
                        snapshot   <= digit_data;
                        frame_tick <= 1'b1;
`ifdef SEG_LZB_EN
                        blank_q    <= lz_fresh;
`endif
                    end
                end
            end else if ((state == SHOW) && last) begin
                state    <= GAP;
                timer    <= '0;
                dig_en_n <= '1;
                num      <= 4'h0;
                seg_n    <= SEG_BLANK;
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed + random stimulus against a behavioural model
// of the scan (remaining-cycle countdowns, digit numbers as ints, segment
// shapes spelled out as letter strings).
module tb_seg_scan_ctrl;

    localparam int D  = 4;
    localparam int DW = 4;
    localparam int BL = 1;

    logic          clk = 1'b0;
    logic          rst, scan_en;
    logic [D-1:0]  digit_mask;
    logic [4*D-1:0] digit_data;
    logic [D-1:0]  dig_en_n;
    logic [3:0]    num;
    logic [7:0]    seg_n;
    logic          frame_tick;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_no = 0;

    seg_scan_ctrl #(.DIGITS(D), .DWELL_CYC(DW), .BLANK_CYC(BL)) dut (
        .clk        (clk),
        .rst        (rst),
        .scan_en    (scan_en),
        .digit_mask (digit_mask),
        .digit_data (digit_data),
        .dig_en_n   (dig_en_n),
        .num        (num),
        .seg_n      (seg_n),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Lit segments for each hex digit, by segment letter.
    string shapes [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                           "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                           "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    function automatic logic [7:0] seg_of(input int v);
        logic [7:0] r;
        string s;
        r = 8'hFF;
        s = shapes[v];
        for (int k = 0; k < s.len(); k++) begin
            int b;
            b = int'(s[k]) - 97;
            r[b] = 1'b0;
        end
        return r;
    endfunction

    // ---- behavioural model ----
    int         m_mode;     // 0 dark/idle, 1 lit, 2 gap
    int         m_cur;
    int         m_rem;
    int         m_hi, m_lo;
    logic [15:0] m_snap;
    logic [3:0]  m_smask;
    logic [3:0]  e_en, e_num;
    logic [7:0]  e_seg;
    logic        e_tick;

    function automatic int nib(input logic [15:0] d, input int i);
        return int'((d >> (4 * i)) & 16'hF);
    endfunction

    task automatic m_dark();
        e_en = 4'hF; e_num = 4'h0; e_seg = 8'hFF;
    endtask

    task automatic m_light();
        bit blank;
        m_mode = 1;
        m_rem  = DW;
        e_en   = 4'hF;
        e_en[m_cur] = 1'b0;
        blank = 1'b0;
`ifdef SEG_LZB_EN
        blank = m_smask[m_cur] && (m_cur > m_hi) && (m_cur != m_lo);
`endif
        if (blank) begin
            e_num = 4'h0; e_seg = 8'hFF;
        end else begin
            e_num = 4'(nib(m_snap, m_cur));
            e_seg = seg_of(nib(m_snap, m_cur));
        end
    endtask

    task automatic m_start_frame();
        m_snap  = digit_data;
        m_smask = digit_mask;
        m_lo = -1; m_hi = -1;
        for (int i = D - 1; i >= 0; i--) if (digit_mask[i]) m_lo = i;
        for (int i = 0; i < D; i++) if (digit_mask[i] && nib(digit_data, i) != 0) m_hi = i;
        m_cur  = m_lo;
        e_tick = 1'b1;
        m_light();
    endtask

    task automatic m_advance();
        int nxt;
        if (digit_mask == 4'h0) begin
            m_mode = 0; m_dark();
            return;
        end
        nxt = -1;
        for (int i = D - 1; i > m_cur; i--) if (digit_mask[i]) nxt = i;
        if (nxt < 0) m_start_frame();
        else begin
            m_cur = nxt;
            m_light();
        end
    endtask

    task automatic model_step();
        e_tick = 1'b0;
        if (rst) begin
            m_mode = 0; m_cur = 0; m_snap = '0; m_dark();
        end else if (!scan_en) begin
            m_mode = 0; m_dark();
        end else begin
            case (m_mode)
                0: if (digit_mask != 4'h0) m_start_frame();
                1: begin
                    m_rem--;
                    if (m_rem == 0) begin
                        if (BL > 0) begin
                            m_mode = 2; m_rem = BL; m_dark();
                        end else m_advance();
                    end
                end
                default: begin
                    m_rem--;
                    if (m_rem == 0) m_advance();
                end
            endcase
        end
    endtask

    task automatic check_model();
        n_cmp++;
        assert ({dig_en_n, num, seg_n, frame_tick} === {e_en, e_num, e_seg, e_tick})
        else begin
            n_bad++;
            $error("FAIL model cyc %0d: got en=%b num=%h seg=%h tick=%b, want en=%b num=%h seg=%h tick=%b",
                   cyc_no, dig_en_n, num, seg_n, frame_tick, e_en, e_num, e_seg, e_tick);
        end
    endtask

    // One clock: model and DUT both see the inputs set before the edge.
    task automatic cyc();
        @(posedge clk);
        cyc_no++;
        model_step();
        #1;
        check_model();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        rst = 1'b1; scan_en = 1'b0; digit_mask = 4'h0; digit_data = 16'h0;
        m_mode = 0; m_cur = 0; m_rem = 0; m_snap = '0; m_smask = '0;
        m_hi = -1; m_lo = -1; e_tick = 1'b0;
        m_dark();
        @(negedge clk);
        run(2);
        n_cmp++;
        assert ({dig_en_n, num, seg_n, frame_tick} === {4'hF, 4'h0, 8'hFF, 1'b0})
        else begin
            n_bad++;
            $error("FAIL reset: got en=%b num=%h seg=%h tick=%b", dig_en_n, num, seg_n, frame_tick);
        end
        rst = 1'b0;
        run(2);

        // 1: full scan of 4321
        scan_en = 1'b1; digit_mask = 4'hF; digit_data = 16'h4321;
        cyc();
        n_cmp++;
        assert ({dig_en_n, num, seg_n, frame_tick} === {4'b1110, 4'h1, 8'hF9, 1'b1})
        else begin
            n_bad++;
            $error("FAIL first_show: got en=%b num=%h seg=%h tick=%b", dig_en_n, num, seg_n, frame_tick);
        end
        run(45);

        // 2: sparse mask, hex letters
        digit_mask = 4'b0101; digit_data = 16'h0A0B;
        run(30);

        // 3: data change mid-frame is deferred to the next snapshot
        digit_mask = 4'hF; digit_data = 16'h4321;
        run(26);
        digit_data = 16'h9999;
        run(40);

        // 4: drop and re-assert scan_en during SHOW
        run(2);
        scan_en = 1'b0;
        cyc();
        n_cmp++;
        assert ({dig_en_n, seg_n} === {4'hF, 8'hFF})
        else begin
            n_bad++;
            $error("FAIL scan_off: got en=%b seg=%h want en=1111 seg=ff", dig_en_n, seg_n);
        end
        scan_en = 1'b1;
        run(12);

        // 5: reset pulse during a gap (bounded search for the gap)
        for (int i = 0; i < 50 && m_mode != 2; i++) cyc();
        n_cmp++;
        assert (m_mode == 2)
        else begin
            n_bad++;
            $error("FAIL gap_timeout: no gap seen within 50 cycles, mode=%0d want 2", m_mode);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        run(25);

        // Single enabled digit, then mask cleared mid-dwell
        digit_mask = 4'b0100; digit_data = 16'h0700;
        run(20);
        digit_mask = 4'hF;
        run(7);
        digit_mask = 4'h0;
        run(10);

        // Leading-zero patterns (plain display unless blanking is built in)
        digit_mask = 4'hF; digit_data = 16'h0050;
        run(40);
        digit_data = 16'h0000;
        run(40);

        // Random soak
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) digit_data = 16'($urandom);
            if ($urandom_range(0, 15) == 0) digit_mask = 4'($urandom);
            if (scan_en && $urandom_range(0, 39) == 0) scan_en = 1'b0;
            else if (!scan_en && $urandom_range(0, 3) == 0) scan_en = 1'b1;
            rst = ($urandom_range(0, 199) == 0);
            cyc();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
